// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - multi-phase reset/bring-up sequencer with per-phase flag pulses and cross-domain sync.
// Optional macro RESET_SEQUENCER_SYNC_TIMEOUT_EN bounds each SYNC wait and raises a sticky SyncTimeout.
module reset_sequencer #(
    parameter int                            PHASES        = 3,
    parameter int                            CNTWIDTH      = 20,
    parameter logic [PHASES*CNTWIDTH-1:0]    PHASE_CYCLES  = {20'd1024, 20'd25000, 20'd625000},
    parameter int                            SYNC_CHANNELS = 2,
    parameter int                            SYNC_TIMEOUT  = 4096
) (
    input  logic                          clk,
    input  logic                          sync_rst_in,
    input  logic                          clk_en,
    input  logic                          sync_rst_Trigger,
    input  logic [SYNC_CHANNELS-1:0]      SyncIn,
    output logic [PHASES-1:0]             PhasePulse,
    output logic [$clog2(PHASES)-1:0]     PhaseIndex,
    output logic                          Busy,
    output logic                          Done,
    output logic                          SyncTimeout
);

    localparam int IDXW = $clog2(PHASES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_COUNT,
        S_SYNC,
        S_DONE
    } state_t;

    state_t                     r_state;
    logic [7:0]                 r_start_sr;
    logic [CNTWIDTH-1:0]        r_cnt;
    logic [IDXW-1:0]            r_idx;
    logic [SYNC_CHANNELS-1:0]   r_cap;

    logic [CNTWIDTH-1:0]        w_limit [PHASES];
    logic                       w_match;
    logic                       w_last;
    logic                       w_sync_all;
    logic                       w_fire;
    logic                       w_to_hit;
    logic [PHASES-1:0]          w_onehot;

    if (PHASES < 2) begin : g_bad_phases
        $error("reset_sequencer: PHASES must be at least 2");
    end
    if (SYNC_CHANNELS < 1) begin : g_bad_channels
        $error("reset_sequencer: SYNC_CHANNELS must be at least 1");
    end
    if (SYNC_TIMEOUT < 1) begin : g_bad_timeout
        $error("reset_sequencer: SYNC_TIMEOUT must be at least 1");
    end

    // An all-ones limit would leave the counter no value past its terminal count.
    for (genvar gp = 0; gp < PHASES; gp++) begin : g_limit
        assign w_limit[gp] = PHASE_CYCLES[gp*CNTWIDTH +: CNTWIDTH];
        if (PHASE_CYCLES[gp*CNTWIDTH +: CNTWIDTH] == {CNTWIDTH{1'b1}}) begin : g_bad_limit
            $error("reset_sequencer: PHASE_CYCLES slice is all-ones");
        end
    end

    assign w_match    = (r_state == S_COUNT) && (r_cnt == w_limit[r_idx]);
    assign w_last     = (r_idx == IDXW'(PHASES - 1));
    assign w_sync_all = &(r_cap | SyncIn);
    assign w_fire     = clk_en && !sync_rst_Trigger && w_match;
    assign w_onehot   = {{(PHASES-1){1'b0}}, 1'b1} << r_idx;

    assign PhasePulse = w_fire ? w_onehot : '0;
    assign PhaseIndex = r_idx;
    assign Busy       = (r_state == S_START) || (r_state == S_COUNT) || (r_state == S_SYNC);
    assign Done       = (r_state == S_DONE);

`ifdef RESET_SEQUENCER_SYNC_TIMEOUT_EN
    localparam int TOW = $clog2(SYNC_TIMEOUT + 1);

    logic [TOW-1:0] r_to_cnt;
    logic           r_to_flag;

    assign w_to_hit    = (r_state == S_SYNC) && (r_to_cnt == TOW'(SYNC_TIMEOUT - 1));
    assign SyncTimeout = r_to_flag;

    // Counter sits at zero outside SYNC, so every SYNC entry starts a fresh window.
    always_ff @(posedge clk or posedge sync_rst_in) begin
        if (sync_rst_in) begin
            r_to_cnt  <= '0;
            r_to_flag <= 1'b0;
        end else if (clk_en) begin
            if (sync_rst_Trigger || (r_state != S_SYNC)) begin
                r_to_cnt <= '0;
            end else begin
                r_to_cnt <= r_to_cnt + 1'b1;
                if (w_to_hit && !w_sync_all) begin
                    r_to_flag <= 1'b1;
                end
            end
        end
    end
`else
    assign w_to_hit    = 1'b0;
    assign SyncTimeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge sync_rst_in) begin
        if (sync_rst_in) begin
            r_state    <= S_IDLE;
            r_start_sr <= '0;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_cap      <= '0;
        end else if (clk_en) begin
            r_start_sr <= {r_start_sr[6:0], 1'b1};
            if (sync_rst_Trigger) begin
                r_state <= S_START;
                r_cnt   <= '0;
                r_idx   <= '0;
                r_cap   <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (r_start_sr[6] && !r_start_sr[7]) begin
                            r_state <= S_START;
                        end
                    end
                    S_START: begin
                        r_state <= S_COUNT;
                        r_cnt   <= '0;
                        r_idx   <= '0;
                    end
                    S_COUNT: begin
                        if (w_match) begin
                            if (w_last) begin
                                r_state <= S_DONE;
                            end else begin
                                r_state <= S_SYNC;
                                r_cnt   <= '0;
                            end
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    S_SYNC: begin
                        if (w_sync_all || w_to_hit) begin
                            r_state <= S_COUNT;
                            r_cap   <= '0;
                            r_cnt   <= '0;
                            r_idx   <= r_idx + 1'b1;
                        end else begin
                            r_cap <= r_cap | SyncIn;
                        end
                    end
                    S_DONE: begin
                        r_state <= S_DONE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
